// File: rtl/adder_acc_32bit.sv
// adder_acc_32bit: packet accumulator behind the 32-bit adder datapath.
// It sums the words of each packet modulo 2^WIDTH and counts them, saturating
// the count. It also records whether any carry out of the top bit occurred.
// One result per packet is held on a valid/ready output until it is taken.
module adder_acc_32bit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic [CNT_W-1:0] out_count,
  output logic             out_ovf
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   acc_q, acc_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               ovf_q, ovf_d;
  logic [WIDTH-1:0]   out_sum_q, out_sum_d;
  logic [CNT_W-1:0]   out_count_q, out_count_d;
  logic               out_ovf_q, out_ovf_d;

  logic               in_fire;
  logic               out_fire;
  logic [WIDTH:0]     sum_ext;
  logic [CNT_W-1:0]   cnt_inc;

  // Ready/valid are pure decodes of the state register, so there is no
  // combinational path from out_ready back to in_ready.
  assign in_ready  = (state_q != HOLD);
  assign out_valid = (state_q == HOLD);
  assign in_fire   = in_valid && in_ready;
  assign out_fire  = out_valid && out_ready;

  // The extra top bit captures the carry out of the WIDTH-bit sum.
  assign sum_ext = {1'b0, acc_q} + {1'b0, in_data};
  assign cnt_inc = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);

  assign out_sum   = out_sum_q;
  assign out_count = out_count_q;
  assign out_ovf   = out_ovf_q;

  // Next-state, accumulator update and result capture on the last word.
  always_comb begin
    // NOTE: every target gets a default first so no path leaves it unassigned; otherwise a latch is inferred.
    state_d     = state_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    ovf_d       = ovf_q;
    out_sum_d   = out_sum_q;
    out_count_d = out_count_q;
    out_ovf_d   = out_ovf_q;

    unique case (state_q)
      IDLE: begin
        if (in_fire) begin
          acc_d = in_data;
          cnt_d = CNT_W'(1);
          ovf_d = 1'b0;
          if (in_last) begin
            state_d     = HOLD;
            out_sum_d   = in_data;
            out_count_d = CNT_W'(1);
            out_ovf_d   = 1'b0;
          end else begin
            state_d = ACCUM;
          end
        end
      end
      ACCUM: begin
        if (in_fire) begin
          acc_d = sum_ext[WIDTH-1:0];
          ovf_d = ovf_q | sum_ext[WIDTH];
          cnt_d = cnt_inc;
          if (in_last) begin
            state_d     = HOLD;
            out_sum_d   = sum_ext[WIDTH-1:0];
            out_count_d = cnt_inc;
            out_ovf_d   = ovf_q | sum_ext[WIDTH];
          end
        end
      end
      HOLD: begin
        if (out_fire) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and result registers; synchronous reset discards any partial packet.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (rst) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      cnt_q       <= '0;
      ovf_q       <= 1'b0;
      out_sum_q   <= '0;
      out_count_q <= '0;
      out_ovf_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      ovf_q       <= ovf_d;
      out_sum_q   <= out_sum_d;
      out_count_q <= out_count_d;
      out_ovf_q   <= out_ovf_d;
    end
  end

endmodule

// File: tb/tb_adder_acc_32bit.sv
// Bench for adder_acc_32bit: directed packets with hand-computed results.
// The driver pushes each packet's expected result into a queue. Monitors pop
// and compare on every output handshake. A second instance with a 2-bit
// counter shares the stimulus to exercise count saturation.
module tb_adder_acc_32bit;

  typedef struct {
    logic [31:0] sum;
    logic [7:0]  cnt;
    logic        ovf;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready, in_ready2;
  logic [31:0] in_data;
  logic        in_last;
  logic        out_valid, out_valid2;
  logic        out_ready;
  logic [31:0] out_sum, out_sum2;
  logic [7:0]  out_count;
  logic [1:0]  out_count2;
  logic        out_ovf, out_ovf2;

  int          n_checks = 0;
  int          n_fail   = 0;
  exp_t        q1[$];
  exp_t        q2[$];
  logic [31:0] pkt[$];

  always #5 clk = ~clk;

  adder_acc_32bit #(.WIDTH(32), .CNT_W(8)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_sum(out_sum), .out_count(out_count), .out_ovf(out_ovf)
  );

  adder_acc_32bit #(.WIDTH(32), .CNT_W(2)) dut_sat (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready2), .in_data(in_data), .in_last(in_last),
    .out_valid(out_valid2), .out_ready(out_ready),
    .out_sum(out_sum2), .out_count(out_count2), .out_ovf(out_ovf2)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor for the 8-bit-count instance: compare on each output fire.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && out_valid && out_ready) begin
      if (q1.size() == 0) begin
        check("unexpected_result", 1, 0);
      end else begin
        e = q1.pop_front();
        check("out_sum", out_sum, e.sum);
        check("out_count", out_count, e.cnt);
        check("out_ovf", out_ovf, e.ovf);
      end
    end
  end

  // Monitor for the saturating 2-bit-count instance.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && out_valid2 && out_ready) begin
      if (q2.size() == 0) begin
        check("sat_unexpected_result", 1, 0);
      end else begin
        e = q2.pop_front();
        check("sat_out_sum", out_sum2, e.sum);
        check("sat_out_count", out_count2, e.cnt);
        check("sat_out_ovf", out_ovf2, e.ovf);
      end
    end
  end

  // Inputs change 1 time unit after the rising edge.
  task automatic send_word(input logic [31:0] d, input logic last, input bit gaps);
    bit fired = 0;
    if (gaps) begin
      for (int g = 0; g < 4 && $urandom_range(0, 1) == 1; g++) begin
        in_valid = 1'b0;
        in_last  = 1'($urandom_range(0, 1));
        in_data  = $urandom;
        @(posedge clk); #1;
      end
    end
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    for (int t = 0; t < 50 && !fired; t++) begin
      @(negedge clk);
      fired = in_ready;
      @(posedge clk); #1;
    end
    if (!fired) check("in_accept_timeout", 0, 1);
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic send_packet(input bit push, input bit gaps,
                             input logic [31:0] e_sum, input int e_cnt, input logic e_ovf);
    exp_t e;
    for (int i = 0; i < pkt.size(); i++) send_word(pkt[i], i == pkt.size() - 1, gaps);
    check("valid_after_last", out_valid, 1);
    check("ready_low_in_hold", in_ready, 0);
    if (push) begin
      e.sum = e_sum; e.cnt = 8'(e_cnt); e.ovf = e_ovf;
      q1.push_back(e);
      e.cnt = 8'((e_cnt > 3) ? 3 : e_cnt);
      q2.push_back(e);
    end
    pkt.delete();
  endtask

  task automatic do_reset(input string tag);
    in_valid = 1'b0;
    in_last  = 1'b0;
    rst      = 1'b1;
    @(posedge clk); #1;
    rst      = 1'b0;
    check({tag, "_out_valid"}, out_valid, 0);
    check({tag, "_in_ready"}, in_ready, 1);
    check({tag, "_out_sum"}, out_sum, 0);
    check({tag, "_out_count"}, out_count, 0);
    check({tag, "_out_ovf"}, out_ovf, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = '0; in_last = 1'b0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    do_reset("reset");

    // Basic 3-word packet, then back to IDLE the cycle after the result is taken.
    pkt = '{32'h1, 32'h2, 32'h3};
    send_packet(1, 0, 32'h6, 3, 1'b0);
    @(posedge clk); #1;
    check("idle_out_valid", out_valid, 0);
    check("idle_in_ready", in_ready, 1);

    // Wrapping sum sets ovf; the following single-word packet clears it.
    pkt = '{32'hFFFF_FFFF, 32'h2};
    send_packet(1, 0, 32'h1, 2, 1'b1);
    @(posedge clk); #1;
    pkt = '{32'h5};
    send_packet(1, 0, 32'h5, 1, 1'b0);
    @(posedge clk); #1;

    // Repeated carries within one packet.
    pkt = '{32'h8000_0000, 32'h8000_0000, 32'h8000_0000};
    send_packet(1, 0, 32'h8000_0000, 3, 1'b1);
    @(posedge clk); #1;

    // Back-pressure: result held stable and new words refused for 5 cycles.
    out_ready = 1'b0;
    pkt = '{32'h10, 32'h20};
    send_packet(1, 0, 32'h30, 2, 1'b0);
    for (int k = 0; k < 5; k++) begin
      in_valid = 1'b1; in_data = 32'h99; in_last = 1'b1;
      @(negedge clk);
      check("bp_out_valid", out_valid, 1);
      check("bp_in_ready", in_ready, 0);
      check("bp_out_sum", out_sum, 32'h30);
      check("bp_out_count", out_count, 2);
      check("bp_out_ovf", out_ovf, 0);
      @(posedge clk); #1;
    end
    in_valid = 1'b0; in_last = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_release_out_valid", out_valid, 0);
    check("bp_release_in_ready", in_ready, 1);

    // Ten words 1..10 with random bubbles (some carrying a stray in_last).
    for (int i = 1; i <= 10; i++) pkt.push_back(32'(i));
    send_packet(1, 1, 32'd55, 10, 1'b0);
    @(posedge clk); #1;

    // Reset mid-packet after two words.
    send_word(32'hAAAA, 1'b0, 0);
    send_word(32'hBBBB, 1'b0, 0);
    do_reset("reset_mid");

    // Reset while a result is held.
    out_ready = 1'b0;
    pkt = '{32'h3};
    send_packet(0, 0, 32'h0, 0, 1'b0);
    @(posedge clk); #1;
    check("hold_before_reset", out_valid, 1);
    do_reset("reset_hold");
    out_ready = 1'b1;

    pkt = '{32'h7, 32'h8};
    send_packet(1, 0, 32'hF, 2, 1'b0);
    @(posedge clk); #1;

    // Six words: the 2-bit-count instance saturates at 3.
    for (int i = 0; i < 6; i++) pkt.push_back(32'h1);
    send_packet(1, 0, 32'h6, 6, 1'b0);

    for (int t = 0; t < 20 && (q1.size() != 0 || q2.size() != 0); t++) @(posedge clk);
    #1;
    check("scoreboard_drained", q1.size(), 0);
    check("sat_scoreboard_drained", q2.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
